// File: rtl/mandel_pkg.sv
// rtl/mandel_pkg.sv - shared widths, frame defaults and dispatcher state encoding
package mandel_pkg;

    localparam int COORD_W      = 27;
    localparam int FRAC_BITS    = 23;
    localparam int ITER_W       = 13;
    localparam int DEF_H_PIXELS = 640;
    localparam int DEF_V_PIXELS = 480;
    localparam int X_W          = 10;
    localparam int Y_W          = 9;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SETTLE,
        WAIT,
        EMIT
    } disp_state_t;

endpackage

// File: rtl/coord_stepper.sv
// rtl/coord_stepper.sv - raster x/y counters and complex-plane accumulators
module coord_stepper
    import mandel_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic                      step_x,
    input  logic                      next_row,
    input  logic signed [COORD_W-1:0] cr_start,
    input  logic signed [COORD_W-1:0] ci_start,
    input  logic signed [COORD_W-1:0] dx,
    input  logic signed [COORD_W-1:0] dy,
    output logic        [X_W-1:0]     x,
    output logic        [Y_W-1:0]     y,
    output logic signed [COORD_W-1:0] cr,
    output logic signed [COORD_W-1:0] ci
);

    // Frame parameters are frozen at load so input changes mid-frame are invisible.
    logic signed [COORD_W-1:0] cr_start_q;
    logic signed [COORD_W-1:0] dx_q;
    logic signed [COORD_W-1:0] dy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x          <= '0;
            y          <= '0;
            cr         <= '0;
            ci         <= '0;
            cr_start_q <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
        end else if (load) begin
            x          <= '0;
            y          <= '0;
            cr         <= cr_start;
            ci         <= ci_start;
            cr_start_q <= cr_start;
            dx_q       <= dx;
            dy_q       <= dy;
        end else if (next_row) begin
            // Imaginary axis runs top-down, so each row subtracts dy.
            x  <= '0;
            y  <= y + 1'b1;
            cr <= cr_start_q;
            ci <= ci - dy_q;
        end else if (step_x) begin
            x  <= x + 1'b1;
            cr <= cr + dx_q;
        end
    end

endmodule

// File: rtl/pixel_dispatcher.sv
// rtl/pixel_dispatcher.sv - walks a frame in raster order, launching the solver per pixel
module pixel_dispatcher
    import mandel_pkg::*;
#(
    parameter int H_PIXELS = DEF_H_PIXELS,
    parameter int V_PIXELS = DEF_V_PIXELS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic signed [COORD_W-1:0] cr_start,
    input  logic signed [COORD_W-1:0] ci_start,
    input  logic signed [COORD_W-1:0] dx,
    input  logic signed [COORD_W-1:0] dy,
    input  logic        [ITER_W-1:0]  max_iter,
    output logic signed [COORD_W-1:0] slv_cr,
    output logic signed [COORD_W-1:0] slv_ci,
    output logic        [ITER_W-1:0]  slv_max_iter,
    output logic                      slv_reset,
    input  logic        [ITER_W-1:0]  slv_iter,
    input  logic                      slv_done,
    output logic        [X_W-1:0]     pix_x,
    output logic        [Y_W-1:0]     pix_y,
    output logic        [ITER_W-1:0]  pix_iter,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic                      busy,
    output logic                      frame_done
);

    localparam logic [X_W-1:0] LAST_X = X_W'(H_PIXELS - 1);
    localparam logic [Y_W-1:0] LAST_Y = Y_W'(V_PIXELS - 1);

    disp_state_t state_q;
    disp_state_t state_d;

    logic load;
    logic step_x;
    logic next_row;
    logic frame_end;
    logic transfer;

    assign transfer = pix_valid && pix_ready;
    assign busy     = (state_q != IDLE);

    coord_stepper u_stepper (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step_x   (step_x),
        .next_row (next_row),
        .cr_start (cr_start),
        .ci_start (ci_start),
        .dx       (dx),
        .dy       (dy),
        .x        (pix_x),
        .y        (pix_y),
        .cr       (slv_cr),
        .ci       (slv_ci)
    );

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        step_x    = 1'b0;
        next_row  = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: state_d = SETTLE;
            // The solver only sees the restart at the end of LAUNCH, so done is
            // not trusted until one cycle later.
            SETTLE: state_d = WAIT;
            WAIT: begin
                if (slv_done) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (transfer) begin
                    if (pix_x == LAST_X && pix_y == LAST_Y) begin
                        frame_end = 1'b1;
                        state_d   = IDLE;
                    end else if (pix_x == LAST_X) begin
                        next_row = 1'b1;
                        state_d  = LAUNCH;
                    end else begin
                        step_x  = 1'b1;
                        state_d = LAUNCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            slv_reset    <= 1'b1;
            slv_max_iter <= '0;
            pix_iter     <= '0;
            pix_valid    <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state_q    <= state_d;
            // Registered from next state so the restart aligns with IDLE and LAUNCH.
            slv_reset  <= (state_d == IDLE) || (state_d == LAUNCH);
            frame_done <= frame_end;
            if (load) begin
                slv_max_iter <= max_iter;
            end
            if (state_q == WAIT && slv_done) begin
                pix_iter  <= slv_iter;
                pix_valid <= 1'b1;
            end else if (transfer) begin
                pix_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pixel_dispatcher.md
PIXEL_DISPATCHER -- requirements
Module: pixel_dispatcher

Interface
REQ-001 Parameter H_PIXELS, default 640, pixels per row.
REQ-002 Parameter V_PIXELS, default 480, rows per frame.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  single-cycle frame start request; ignored unless IDLE.
REQ-006 cr_start, ci_start  in  27 each  signed 4.23 coordinate of pixel (0,0).
REQ-007 dx, dy  in  27 each  signed 4.23 per-pixel real step and per-row imaginary step.
REQ-008 max_iter  in  13  iteration limit forwarded to the solver.
REQ-009 slv_cr, slv_ci  out  27 each  solver c inputs, registered.
REQ-010 slv_max_iter  out  13  latched max_iter, registered.
REQ-011 slv_reset  out  1  solver synchronous active-high restart, registered.
REQ-012 slv_iter  in  13  solver iteration count.
REQ-013 slv_done  in  1  solver done level.
REQ-014 pix_x  out  10, pix_y  out  9, pix_iter  out  13  result pixel.
REQ-015 pix_valid  out  1 / pix_ready  in  1  result handshake.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 frame_done  out  1  one-cycle pulse after the last pixel transfers.

Function
REQ-018 States: IDLE, LAUNCH, SETTLE, WAIT, EMIT.
REQ-019 IDLE: slv_reset=1, pix_valid=0; on start=1, latch cr_start, ci_start, dx, dy and max_iter; set x=0, y=0, slv_cr=cr_start, slv_ci=ci_start; go to LAUNCH.
REQ-020 LAUNCH: slv_reset=1 for exactly one cycle; go to SETTLE.
REQ-021 SETTLE: slv_reset=0; slv_done ignored; this cycle masks the stale done from the previous pixel; go to WAIT.
REQ-022 WAIT: stay until slv_done=1; then capture slv_iter into pix_iter, set pix_valid=1, go to EMIT.
REQ-023 EMIT: hold pix_x, pix_y, pix_iter and pix_valid stable until pix_ready=1; a transfer happens on any cycle with pix_valid=1 and pix_ready=1, including the first EMIT cycle.
REQ-024 After a transfer at x<H_PIXELS-1: x+1, slv_cr += dx, go to LAUNCH.
REQ-025 After a transfer at x=H_PIXELS-1 and y<V_PIXELS-1: x=0, slv_cr=cr_start, y+1, slv_ci -= dy, go to LAUNCH.
REQ-026 After a transfer at the last pixel: pulse frame_done, go to IDLE; no pixel beyond (H_PIXELS-1, V_PIXELS-1) is emitted.
REQ-027 Coordinate arithmetic is 27-bit two's-complement with modular wrap and no saturation; no multipliers are used.
REQ-028 pix_valid drops in the cycle after the transfer.
REQ-029 Cycles per pixel = 3 + solver run time + handshake wait.
REQ-030 start while busy has no effect; latched parameters stay constant for the whole frame.

Reset
REQ-031 When reset is low, the block goes to IDLE immediately.
REQ-032 Reset values: slv_reset=1, pix_valid=0, busy=0, frame_done=0, and x, y, pix_iter, slv_cr, slv_ci, slv_max_iter all 0.
REQ-033 Reset asserted mid-frame abandons the frame with no further pixels and no frame_done pulse.

Structure
REQ-034 Shared package mandel_pkg holds: COORD_W=27, FRAC_BITS=23, ITER_W=13, default H_PIXELS/V_PIXELS, and the dispatcher state enum.
REQ-035 One sub-module, coord_stepper, holds the x/y counters and the cr/ci accumulators, with inputs load, step_x and next_row.

Verification
REQ-036 The bench instantiates the real solver. H=1, V=1, cr_start=ci_start=0, max_iter=1000, pix_ready=1 -> one pixel (0,0) with pix_iter=1000, then a frame_done pulse.
REQ-037 H=1, V=1, cr_start=27'sh1000000 (2.0), ci_start=0 -> pix_iter=1; WAIT is entered exactly 2 cycles after LAUNCH.
REQ-038 H=4, V=3, cr_start=-2.0, dx=0.5, ci_start=1.0, dy=0.5 -> 12 pixels in raster order; pixel (3,2) is launched with slv_cr=-0.5 and slv_ci=0.0.
REQ-039 pix_ready held low for 10 cycles during EMIT -> pix_valid and pixel data stay stable, no solver relaunch, and no pixel is lost or duplicated.
REQ-040 Reset pulsed low during WAIT of pixel 5 -> immediate IDLE with slv_reset=1 and no frame_done; a following start begins again at (0,0).
REQ-041 start pulsed during WAIT -> ignored; the frame completes normally with one frame_done.
